// File: rtl/mem_rr_arb.sv
// Round-robin arbiter between N native valid/ready requesters and one memory master port.
// A bus watchdog aborts a stalled transaction and completes it with an error word.
//
// state | meaning
// IDLE  | no transaction in flight; the next owner is chosen from last+1 upward
// BUSY  | mem_* presented to the slave, waiting for mem_ready or the watchdog limit
module mem_rr_arb #(
  parameter int          N        = 4,
  parameter int          IDW      = 2,
  parameter int          TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [N*32-1:0]   req_addr,
  input  logic [N*32-1:0]   req_wdata,
  input  logic [N*4-1:0]    req_wstrb,
  output logic [31:0]       req_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  output logic [IDW-1:0]    grant,
  output logic              timeout_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         r_state, w_state_nxt;
  logic [IDW-1:0] r_last, r_grant;
  logic [15:0]    r_wdog;
  logic           r_mem_valid, r_tout;
  logic [31:0]    r_addr, r_wdata;
  logic [3:0]     r_wstrb;

  logic [IDW-1:0] w_pick;
  logic           w_any;
  logic [31:0]    w_addr, w_wdata;
  logic [3:0]     w_wstrb;
  logic           w_wdog_hit, w_done, w_abort;

  // Walk offsets from N down to 1 so the nearest requester after r_last wins.
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (req_valid[IDW'((int'(r_last) + k) % N)]) begin
        w_pick = IDW'((int'(r_last) + k) % N);
        w_any  = 1'b1;
      end
    end
  end

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_wstrb = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pick == IDW'(i)) begin
        w_addr  = req_addr[32*i +: 32];
        w_wdata = req_wdata[32*i +: 32];
        w_wstrb = req_wstrb[4*i +: 4];
      end
    end
  end

  // Completion strobes are suppressed while reset is asserted.
  assign w_wdog_hit = (TIMEOUT != 0) && (r_wdog == 16'(TIMEOUT - 1));
  assign w_done     = rstn && (r_state == BUSY) && (mem_ready || w_wdog_hit);
  assign w_abort    = w_done && !mem_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any)  w_state_nxt = BUSY;
      BUSY:    if (w_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mem_valid <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_grant     <= '0;
      r_last      <= IDW'(N - 1);
      r_wdog      <= '0;
      r_tout      <= 1'b0;
    end else begin
      r_tout <= 1'b0;
      if (r_state == IDLE) begin
        if (w_any) begin
          r_mem_valid <= 1'b1;
          r_addr      <= w_addr;
          r_wdata     <= w_wdata;
          r_wstrb     <= w_wstrb;
          r_grant     <= w_pick;
          r_wdog      <= '0;
        end
      end else if (w_done) begin
        r_mem_valid <= 1'b0;
        r_last      <= r_grant;
        r_tout      <= w_abort;
      end else if (r_wdog != 16'hFFFF) begin
        r_wdog <= r_wdog + 16'd1;
      end
    end
  end

  assign req_ready   = w_done ? ({{(N-1){1'b0}}, 1'b1} << r_grant) : '0;
  assign req_rdata   = w_abort ? ERR_DATA : mem_rdata;
  assign mem_valid   = r_mem_valid;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign mem_wstrb   = r_wstrb;
  assign grant       = r_grant;
  assign timeout_err = r_tout;

endmodule

// File: tb/tb_mem_rr_arb.sv
// Bench for mem_rr_arb: per-cycle vector table, a reset corner sequence,
// and random traffic checked against a transaction-level reference model.
module tb_mem_rr_arb;
  localparam int          N   = 4;
  localparam int          IDW = 2;
  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  logic              clk = 1'b0;
  logic              rstn;
  logic [N-1:0]      req_valid, req_ready;
  logic [N*32-1:0]   req_addr, req_wdata;
  logic [N*4-1:0]    req_wstrb;
  logic [31:0]       req_rdata, mem_addr, mem_wdata, mem_rdata;
  logic              mem_valid, mem_ready, timeout_err;
  logic [3:0]        mem_wstrb;
  logic [IDW-1:0]    grant;

  logic [31:0] a_addr[N];
  logic [31:0] a_wdata[N];
  logic [3:0]  a_wstrb[N];

  always #5 clk = ~clk;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[32*i +: 32] = a_addr[i];
      req_wdata[32*i +: 32] = a_wdata[i];
      req_wstrb[4*i +: 4]  = a_wstrb[i];
    end
  end

  mem_rr_arb #(.N(N), .IDW(IDW), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_rdata(req_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rstn;
    logic [3:0]  rv;
    logic        mr;
    logic [3:0]  rr;
    logic        mv;
    logic [1:0]  g;
    logic        te;
    logic        err;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rs, input logic [3:0] rv, input logic mr,
                              input logic [3:0] rr, input logic mv, input logic [1:0] g,
                              input logic te, input logic err, input logic [31:0] addr);
    vec_t v;
    v.rstn = rs; v.rv = rv; v.mr = mr; v.rr = rr; v.mv = mv;
    v.g = g; v.te = te; v.err = err; v.addr = addr;
    tbl.push_back(v);
  endfunction

  // Reference model: one outstanding transaction, ownership rotates by distance from last owner.
  logic        m_busy, m_terr;
  int          m_own, m_last, m_age;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;

  function automatic int rr_pick(input logic [N-1:0] rv, input int last);
    int best, bd, d;
    best = -1;
    bd   = N;
    for (int i = 0; i < N; i++) begin
      d = (i - last - 1 + N) % N;
      if (rv[i] && d < bd) begin
        bd   = d;
        best = i;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_terr = 1'b0; m_own = 0; m_last = N - 1; m_age = 0;
    m_addr = '0; m_wdata = '0; m_wstrb = '0;
  endtask

  initial begin
    int p;
    logic done, abrt;
    logic [3:0] exp_rr;

    rstn = 1'b0; req_valid = '0; mem_ready = 1'b0; mem_rdata = '0;
    a_addr[0] = 32'h0000_A000; a_addr[1] = 32'h0000_A001;
    a_addr[2] = 32'h0000_1000; a_addr[3] = 32'h0000_A003;
    for (int i = 0; i < N; i++) begin
      a_wdata[i] = 32'h5500_0000 + i;
      a_wstrb[i] = 4'(i);
    end

    // single requester 2, ready in BUSY cycle 4
    add(1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 32'h0);
    add(1, 4'b0100, 0, 4'b0000, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) add(1, 4'b0100, 0, 4'b0000, 1, 2, 0, 0, 32'h1000);
    add(1, 4'b0100, 1, 4'b0100, 1, 2, 0, 0, 32'h1000);
    add(1, 4'b0000, 0, 4'b0000, 0, 2, 0, 0, 32'h1000);
    // reset, then fairness with all four requesting
    add(0, 4'b1111, 0, 4'b0000, 0, 2, 0, 0, 32'h1000);
    add(1, 4'b1111, 0, 4'b0000, 0, 0, 0, 0, 32'h0);
    for (int t = 0; t < 6; t++) begin
      p = t % 4;
      add(1, 4'b1111, 1, 4'(1 << p), 1, 2'(p), 0, 0, a_addr[p]);
      add(1, (t == 5) ? 4'b0000 : 4'b1111, 0, 4'b0000, 0, 2'(p), 0, 0, a_addr[p]);
    end
    // skip: last=1, requests on 0 and 3
    add(1, 4'b1001, 0, 4'b0000, 0, 1, 0, 0, 32'h0000_A001);
    add(1, 4'b1001, 1, 4'b1000, 1, 3, 0, 0, 32'h0000_A003);
    add(1, 4'b1001, 0, 4'b0000, 0, 3, 0, 0, 32'h0000_A003);
    add(1, 4'b1001, 1, 4'b0001, 1, 0, 0, 0, 32'h0000_A000);
    // watchdog abort on requester 1, then requester 2 granted
    add(1, 4'b0010, 0, 4'b0000, 0, 0, 0, 0, 32'h0000_A000);
    for (int i = 1; i < TO; i++) add(1, 4'b0010, 0, 4'b0000, 1, 1, 0, 0, 32'h0000_A001);
    add(1, 4'b0010, 0, 4'b0010, 1, 1, 0, 1, 32'h0000_A001);
    add(1, 4'b0100, 0, 4'b0000, 0, 1, 1, 0, 32'h0000_A001);
    // ready coincident with the watchdog limit
    for (int i = 1; i < TO; i++) add(1, 4'b0100, 0, 4'b0000, 1, 2, 0, 0, 32'h1000);
    add(1, 4'b0100, 1, 4'b0100, 1, 2, 0, 0, 32'h1000);
    add(1, 4'b0000, 0, 4'b0000, 0, 2, 0, 0, 32'h1000);

    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      rstn = tbl[i].rstn; req_valid = tbl[i].rv; mem_ready = tbl[i].mr;
      mem_rdata = 32'hD000_0000 + i;
      @(negedge clk);
      chk($sformatf("tbl%0d req_ready", i), 32'(req_ready), 32'(tbl[i].rr));
      chk($sformatf("tbl%0d mem_valid", i), 32'(mem_valid), 32'(tbl[i].mv));
      chk($sformatf("tbl%0d grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("tbl%0d timeout_err", i), 32'(timeout_err), 32'(tbl[i].te));
      chk($sformatf("tbl%0d req_rdata", i), req_rdata, tbl[i].err ? ERR : mem_rdata);
      chk($sformatf("tbl%0d mem_addr", i), mem_addr, tbl[i].addr);
      @(posedge clk);
      #1;
    end

    // reset mid-transaction: no completion strobe, then requester 0 beats 1
    req_valid = 4'b0010; mem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_seq busy mem_valid", 32'(mem_valid), 32'd1);
    chk("rst_seq busy grant", 32'(grant), 32'd1);
    chk("rst_seq busy mem_wstrb", 32'(mem_wstrb), 32'd1);
    @(posedge clk); #1;
    rstn = 1'b0; mem_ready = 1'b1; req_valid = 4'b0011;
    @(negedge clk);
    chk("rst_seq ready during reset", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_seq mem_valid after reset", 32'(mem_valid), 32'd0);
    chk("rst_seq grant after reset", 32'(grant), 32'd0);
    chk("rst_seq idle ready ignored", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_seq regrant valid", 32'(mem_valid), 32'd1);
    chk("rst_seq regrant grant", 32'(grant), 32'd0);
    chk("rst_seq regrant wdata", mem_wdata, 32'h5500_0000);
    @(posedge clk); #1;

    // randomized traffic against the model
    rstn = 1'b0; req_valid = '0;
    @(posedge clk); #1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      rstn      = ($urandom_range(0, 199) != 0);
      req_valid = 4'($urandom);
      mem_ready = ($urandom_range(0, 4) == 0);
      mem_rdata = $urandom;
      for (int i = 0; i < N; i++) begin
        a_addr[i]  = $urandom;
        a_wdata[i] = $urandom;
        a_wstrb[i] = 4'($urandom);
      end
      @(negedge clk);
      done   = rstn && m_busy && (mem_ready || m_age == TO);
      abrt   = done && !mem_ready;
      exp_rr = done ? 4'(1 << m_own) : 4'b0000;
      chk("rnd req_ready", 32'(req_ready), 32'(exp_rr));
      chk("rnd req_rdata", req_rdata, abrt ? ERR : mem_rdata);
      chk("rnd mem_valid", 32'(mem_valid), 32'(m_busy));
      chk("rnd mem_addr", mem_addr, m_addr);
      chk("rnd mem_wdata", mem_wdata, m_wdata);
      chk("rnd mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
      chk("rnd grant", 32'(grant), 32'(m_own));
      chk("rnd timeout_err", 32'(timeout_err), 32'(m_terr));
      if (!rstn) begin
        model_reset();
      end else begin
        m_terr = 1'b0;
        if (!m_busy) begin
          p = rr_pick(req_valid, m_last);
          if (p >= 0) begin
            m_busy = 1'b1; m_own = p; m_age = 1;
            m_addr = a_addr[p]; m_wdata = a_wdata[p]; m_wstrb = a_wstrb[p];
          end
        end else if (done) begin
          m_busy = 1'b0; m_last = m_own; m_terr = abrt;
        end else begin
          m_age++;
        end
      end
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
